cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Arbitrates completion requests from N_FU execution units onto N_CDB common data
//  bus slots, which feed complete_dest_tag / take_branch / br_result of the ROB.
//  Round-robin, work-conserving, starvation-free. Registered outputs; squashes on flush.
// PARAMETERS
//  N_FU    4   number of requesting functional units
//  N_CDB   2   CDB broadcast slots per cycle (= `N_WAY)
//  TAG_W   6   physical tag width (= `CDB_BITS); tag 0 is the null tag
//  XLEN    32  branch target width
// PORTS
//  clock           in   1              system clock
//  reset           in   1              synchronous, active-high
//  flush           in   1              ROB branch_haz; squash all completions
//  fu_valid        in   N_FU           FU i has a completed result
//  fu_tag          in   N_FU*TAG_W     destination tag per FU
//  fu_take_branch  in   N_FU           branch-taken flag per FU
//  fu_br_target    in   N_FU*XLEN      branch target per FU
//  fu_grant        out  N_FU           FU i's request accepted this cycle (comb.)
//  cdb_valid       out  N_CDB          slot carries a completion (registered)
//  cdb_tag         out  N_CDB*TAG_W    broadcast tag; 0 when slot invalid
//  cdb_take_branch out  N_CDB          broadcast branch-taken flag
//  cdb_br_target   out  N_CDB*XLEN     broadcast branch target
//  rr_ptr          out  $clog2(N_FU)   current highest-priority FU index
// BEHAVIOUR
//  - Reset: cdb_valid/cdb_tag/cdb_take_branch/cdb_br_target = 0, rr_ptr = 0;
//    fu_grant = 0 while reset high.
//  - Eligible FU i: fu_valid[i] && fu_tag[i] != 0. fu_valid with tag 0: never granted.
//  - Scan: FUs visited circularly rr_ptr, rr_ptr+1, ... mod N_FU. First N_CDB eligible
//    FUs granted; k-th winner (k=0..) assigned to CDB slot k. Grants are combinational
//    in the request cycle.
//  - Handshake: FU holds valid/tag/branch fields stable until it sees fu_grant=1;
//    may deassert/advance on the cycle after grant.
//  - Latency: granted in cycle t -> on cdb_* in cycle t+1 (flop at posedge).
//  - Unused slots in t+1: cdb_valid=0 and tag/flag/target = 0.
//  - rr_ptr: if >=1 grant, next = (index of last granted FU + 1) mod N_FU; else unchanged.
//  - Starvation bound: an eligible FU is granted within ceil(N_FU/N_CDB) cycles.
//  - flush=1 in cycle t: fu_grant = 0 in t; cdb_valid = 0 in t+1; rr_ptr unchanged.
//    cdb_* already registered and visible during t are not retracted (ROB ignores
//    completions while branch_haz). FUs must drop requests on flush themselves.
//  - flush and reset both high: reset wins (same result).
//  - Duplicate tags from two FUs: not checked; both granted if eligible.
//  - N_FU <= N_CDB: every eligible FU granted every cycle; rr_ptr still updates.
// TESTING
//  1 reset, then fu_valid=4'b0000 -> fu_grant=0, cdb_valid=2'b00, rr_ptr=0 indefinitely.
//  2 rr_ptr=0, fu_valid=4'b1111, tags 5,6,7,8 held -> t: grant=4'b0011; t+1: cdb_tag={6,5},
//    rr_ptr=2; t+1 grant=4'b1100; t+2: cdb_tag={8,7}, rr_ptr=0.
//  3 fu_valid=4'b0100, tag=9, take_branch=1, target=32'h0000_1040 -> slot0 next cycle:
//    valid=1, tag=9, take_branch=1, target=32'h1040; slot1 all zero; rr_ptr=3.
//  4 fu_valid=4'b0011, fu_tag[0]=0, fu_tag[1]=3 -> only grant[1]=1; cdb_tag slot0=3.
//  5 fu_valid=4'b1111 with flush=1 -> fu_grant=0, next cycle cdb_valid=0, rr_ptr unchanged;
//    flush drops -> normal grants resume from same rr_ptr.
//  6 all FUs valid 20 cycles, random holds -> every FU granted at least once per 2 cycles;
//    no tag broadcast twice per single request.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Round-robin arbiter placing FU completions onto N_CDB registered
//             common-data-bus slots; squashes all grants while flush is high.
//  Revision : 1.0
// ============================================================================
module cdb_arbiter #(
    parameter int N_FU  = 4,
    parameter int N_CDB = 2,
    parameter int TAG_W = 6,
    parameter int XLEN  = 32,
    localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [N_FU-1:0]        fu_valid,
    input  logic [N_FU*TAG_W-1:0]  fu_tag,
    input  logic [N_FU-1:0]        fu_take_branch,
    input  logic [N_FU*XLEN-1:0]   fu_br_target,
    output logic [N_FU-1:0]        fu_grant,
    output logic [N_CDB-1:0]       cdb_valid,
    output logic [N_CDB*TAG_W-1:0] cdb_tag,
    output logic [N_CDB-1:0]       cdb_take_branch,
    output logic [N_CDB*XLEN-1:0]  cdb_br_target,
    output logic [PTR_W-1:0]       rr_ptr
);

    localparam int              CNT_W  = $clog2(N_CDB + 1);
    localparam logic [PTR_W:0]  C_N_FU = (PTR_W + 1)'(N_FU);
    localparam logic [CNT_W-1:0] C_N_CDB = CNT_W'(N_CDB);

    logic [TAG_W-1:0] tag_w [N_FU];
    logic [XLEN-1:0]  tgt_w [N_FU];
    logic [N_FU-1:0]  eligible;

    generate
        for (genvar i = 0; i < N_FU; i++) begin : g_unpack
            assign tag_w[i]    = fu_tag[i*TAG_W +: TAG_W];
            assign tgt_w[i]    = fu_br_target[i*XLEN +: XLEN];
            assign eligible[i] = fu_valid[i] && (tag_w[i] != '0);
        end
    endgenerate

    logic [N_CDB-1:0] cdb_valid_q, cdb_valid_d;
    logic [N_CDB*TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [N_CDB-1:0] cdb_br_q, cdb_br_d;
    logic [N_CDB*XLEN-1:0] cdb_tgt_q, cdb_tgt_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [N_FU-1:0]  grant;
    logic [PTR_W-1:0] slot_src [N_CDB];
    logic [PTR_W-1:0] last_idx;
    logic [CNT_W-1:0] n_won;
    logic [PTR_W:0]   pos;
    logic [PTR_W:0]   pos_nxt;
    logic [PTR_W-1:0] idx;
    logic             blocked;

    assign blocked = reset || flush;

    // Circular scan from rr_ptr; the k-th eligible FU found lands in slot k.
    always_comb begin
        grant       = '0;
        cdb_valid_d = '0;
        last_idx    = rr_ptr_q;
        n_won       = '0;
        pos         = '0;
        idx         = '0;
        for (int k = 0; k < N_CDB; k++) begin
            slot_src[k] = '0;
        end
        for (int j = 0; j < N_FU; j++) begin
            pos = {1'b0, rr_ptr_q} + (PTR_W + 1)'(j);
            if (pos >= C_N_FU) begin
                pos = pos - C_N_FU;
            end
            idx = pos[PTR_W-1:0];
            if (!blocked && eligible[idx] && (n_won < C_N_CDB)) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < N_CDB; k++) begin
                    if (n_won == CNT_W'(k)) begin
                        cdb_valid_d[k] = 1'b1;
                        slot_src[k]    = idx;
                    end
                end
                n_won    = n_won + 1'b1;
                last_idx = idx;
            end
        end
    end

    always_comb begin
        pos_nxt = {1'b0, last_idx} + 1'b1;
        if (pos_nxt >= C_N_FU) begin
            pos_nxt = '0;
        end
        rr_ptr_d = (grant != '0) ? pos_nxt[PTR_W-1:0] : rr_ptr_q;
    end

    // Empty slots broadcast all-zero fields so the null tag is seen downstream.
    always_comb begin
        cdb_tag_d = '0;
        cdb_br_d  = '0;
        cdb_tgt_d = '0;
        for (int k = 0; k < N_CDB; k++) begin
            if (cdb_valid_d[k]) begin
                cdb_tag_d[k*TAG_W +: TAG_W] = tag_w[slot_src[k]];
                cdb_br_d[k]                 = fu_take_branch[slot_src[k]];
                cdb_tgt_d[k*XLEN +: XLEN]   = tgt_w[slot_src[k]];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_valid_q <= '0;
            cdb_tag_q   <= '0;
            cdb_br_q    <= '0;
            cdb_tgt_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_br_q    <= cdb_br_d;
            cdb_tgt_q   <= cdb_tgt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign fu_grant        = grant;
    assign cdb_valid       = cdb_valid_q;
    assign cdb_tag         = cdb_tag_q;
    assign cdb_take_branch = cdb_br_q;
    assign cdb_br_target   = cdb_tgt_q;
    assign rr_ptr          = rr_ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Directed and randomized checks of cdb_arbiter against a
//             queue-based round-robin reference model.
//  Revision : 1.0
// ============================================================================
module tb_cdb_arbiter;

    localparam int N_FU  = 4;
    localparam int N_CDB = 2;
    localparam int TAG_W = 6;
    localparam int XLEN  = 32;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   flush;
    logic [N_FU-1:0]        fu_valid;
    logic [N_FU*TAG_W-1:0]  fu_tag;
    logic [N_FU-1:0]        fu_take_branch;
    logic [N_FU*XLEN-1:0]   fu_br_target;
    logic [N_FU-1:0]        fu_grant;
    logic [N_CDB-1:0]       cdb_valid;
    logic [N_CDB*TAG_W-1:0] cdb_tag;
    logic [N_CDB-1:0]       cdb_take_branch;
    logic [N_CDB*XLEN-1:0]  cdb_br_target;
    logic [1:0]             rr_ptr;

    cdb_arbiter #(.N_FU(N_FU), .N_CDB(N_CDB), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .fu_valid        (fu_valid),
        .fu_tag          (fu_tag),
        .fu_take_branch  (fu_take_branch),
        .fu_br_target    (fu_br_target),
        .fu_grant        (fu_grant),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_take_branch (cdb_take_branch),
        .cdb_br_target   (cdb_br_target),
        .rr_ptr          (rr_ptr)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state and the values it predicts.
    int                     m_rr = 0;
    int                     next_tag = 1;
    logic [N_FU-1:0]        exp_grant;
    logic [N_CDB-1:0]       n_valid;
    logic [N_CDB*TAG_W-1:0] n_tag;
    logic [N_CDB-1:0]       n_br;
    logic [N_CDB*XLEN-1:0]  n_tgt;
    int                     n_rr;

    // Build the visiting order, keep the first N_CDB eligible FUs.
    task automatic model_eval();
        int order[$];
        int win[$];
        exp_grant = '0;
        n_valid   = '0;
        n_tag     = '0;
        n_br      = '0;
        n_tgt     = '0;
        n_rr      = m_rr;
        for (int k = 0; k < N_FU; k++) order.push_back((m_rr + k) % N_FU);
        foreach (order[q]) begin
            int f;
            f = order[q];
            if (!reset && !flush && fu_valid[f] && (fu_tag[f*TAG_W +: TAG_W] != 0)
                && (win.size() < N_CDB))
                win.push_back(f);
        end
        foreach (win[s]) begin
            exp_grant[win[s]]         = 1'b1;
            n_valid[s]                = 1'b1;
            n_tag[s*TAG_W +: TAG_W]   = fu_tag[win[s]*TAG_W +: TAG_W];
            n_br[s]                   = fu_take_branch[win[s]];
            n_tgt[s*XLEN +: XLEN]     = fu_br_target[win[s]*XLEN +: XLEN];
        end
        if (win.size() > 0) n_rr = (win[win.size()-1] + 1) % N_FU;
        if (reset) n_rr = 0;
    endtask

    task automatic new_request(input int i);
        fu_tag[i*TAG_W +: TAG_W]      = TAG_W'(next_tag);
        next_tag                      = (next_tag == 63) ? 1 : next_tag + 1;
        fu_take_branch[i]             = 1'($urandom_range(1));
        fu_br_target[i*XLEN +: XLEN]  = $urandom;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        flush          = 1'b0;
        fu_valid       = 4'hF;
        fu_tag         = {6'd8, 6'd7, 6'd6, 6'd5};
        fu_take_branch = 4'hF;
        fu_br_target   = {4{32'hDEAD_BEEF}};
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (fu_grant !== 4'b0000) begin
            n_errors++; $display("FAIL reset_grant got=%b exp=0000", fu_grant);
        end
        n_checks++;
        if (cdb_valid !== 2'b00 || cdb_tag !== '0 || cdb_take_branch !== '0
            || cdb_br_target !== '0 || rr_ptr !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_state got v=%b t=%h b=%b tg=%h rr=%0d exp all 0",
                     cdb_valid, cdb_tag, cdb_take_branch, cdb_br_target, rr_ptr);
        end
        reset    = 1'b0;
        fu_valid = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (fu_grant !== 4'b0000) begin
                n_errors++; $display("FAIL idle_grant got=%b exp=0000", fu_grant);
            end
            @(posedge clock); #1;
            n_checks++;
            if (cdb_valid !== 2'b00 || rr_ptr !== 2'd0) begin
                n_errors++;
                $display("FAIL idle_state got v=%b rr=%0d exp v=00 rr=0", cdb_valid, rr_ptr);
            end
        end
    endtask

    task automatic test_rotation();
        fu_valid       = 4'hF;
        fu_tag         = {6'd8, 6'd7, 6'd6, 6'd5};
        fu_take_branch = 4'h0;
        fu_br_target   = '0;
        #1;
        n_checks++;
        if (fu_grant !== 4'b0011) begin
            n_errors++; $display("FAIL rot_grant0 got=%b exp=0011", fu_grant);
        end
        @(posedge clock); #1;
        n_checks++;
        if (cdb_valid !== 2'b11 || cdb_tag !== {6'd6, 6'd5} || rr_ptr !== 2'd2) begin
            n_errors++;
            $display("FAIL rot_out0 got v=%b tag=%h rr=%0d exp v=11 tag=%h rr=2",
                     cdb_valid, cdb_tag, rr_ptr, {6'd6, 6'd5});
        end
        #1;
        n_checks++;
        if (fu_grant !== 4'b1100) begin
            n_errors++; $display("FAIL rot_grant1 got=%b exp=1100", fu_grant);
        end
        @(posedge clock); #1;
        n_checks++;
        if (cdb_valid !== 2'b11 || cdb_tag !== {6'd8, 6'd7} || rr_ptr !== 2'd0) begin
            n_errors++;
            $display("FAIL rot_out1 got v=%b tag=%h rr=%0d exp v=11 tag=%h rr=0",
                     cdb_valid, cdb_tag, rr_ptr, {6'd8, 6'd7});
        end
        fu_valid = 4'b0000;
    endtask

    task automatic test_branch();
        fu_valid       = 4'b0100;
        fu_tag         = {6'd0, 6'd9, 6'd0, 6'd0};
        fu_take_branch = 4'b0100;
        fu_br_target   = {32'h0, 32'h0000_1040, 32'h0, 32'h0};
        #1;
        n_checks++;
        if (fu_grant !== 4'b0100) begin
            n_errors++; $display("FAIL br_grant got=%b exp=0100", fu_grant);
        end
        @(posedge clock); #1;
        n_checks++;
        if (cdb_valid !== 2'b01 || cdb_tag !== {6'd0, 6'd9} || cdb_take_branch !== 2'b01
            || cdb_br_target !== {32'h0, 32'h0000_1040} || rr_ptr !== 2'd3) begin
            n_errors++;
            $display("FAIL br_out got v=%b tag=%h b=%b tg=%h rr=%0d exp v=01 tag=009 b=01 tg=1040 rr=3",
                     cdb_valid, cdb_tag, cdb_take_branch, cdb_br_target, rr_ptr);
        end
        fu_valid       = 4'b0000;
        fu_take_branch = 4'b0000;
        fu_br_target   = '0;
    endtask

    task automatic test_null_tag();
        fu_valid = 4'b0011;
        fu_tag   = {6'd0, 6'd0, 6'd3, 6'd0};
        #1;
        n_checks++;
        if (fu_grant !== 4'b0010) begin
            n_errors++; $display("FAIL null_grant got=%b exp=0010", fu_grant);
        end
        @(posedge clock); #1;
        n_checks++;
        if (cdb_valid !== 2'b01 || cdb_tag !== {6'd0, 6'd3} || rr_ptr !== 2'd2) begin
            n_errors++;
            $display("FAIL null_out got v=%b tag=%h rr=%0d exp v=01 tag=003 rr=2",
                     cdb_valid, cdb_tag, rr_ptr);
        end
        fu_valid = 4'b0000;
    endtask

    task automatic test_flush();
        fu_valid = 4'hF;
        fu_tag   = {6'd8, 6'd7, 6'd6, 6'd5};
        flush    = 1'b1;
        #1;
        n_checks++;
        if (fu_grant !== 4'b0000) begin
            n_errors++; $display("FAIL flush_grant got=%b exp=0000", fu_grant);
        end
        @(posedge clock); #1;
        n_checks++;
        if (cdb_valid !== 2'b00 || cdb_tag !== '0 || rr_ptr !== 2'd2) begin
            n_errors++;
            $display("FAIL flush_out got v=%b tag=%h rr=%0d exp v=00 tag=0 rr=2",
                     cdb_valid, cdb_tag, rr_ptr);
        end
        flush = 1'b0;
        #1;
        n_checks++;
        if (fu_grant !== 4'b1100) begin
            n_errors++; $display("FAIL flush_resume_grant got=%b exp=1100", fu_grant);
        end
        @(posedge clock); #1;
        n_checks++;
        if (cdb_valid !== 2'b11 || cdb_tag !== {6'd8, 6'd7} || rr_ptr !== 2'd0) begin
            n_errors++;
            $display("FAIL flush_resume_out got v=%b tag=%h rr=%0d exp v=11 rr=0",
                     cdb_valid, cdb_tag, rr_ptr);
        end
        // Move the pointer off zero, then assert reset and flush together.
        fu_valid = 4'b0001;
        @(posedge clock); #1;
        reset    = 1'b1;
        flush    = 1'b1;
        fu_valid = 4'hF;
        #1;
        n_checks++;
        if (fu_grant !== 4'b0000) begin
            n_errors++; $display("FAIL rstflush_grant got=%b exp=0000", fu_grant);
        end
        @(posedge clock); #1;
        n_checks++;
        if (cdb_valid !== 2'b00 || rr_ptr !== 2'd0) begin
            n_errors++;
            $display("FAIL rstflush_out got v=%b rr=%0d exp v=00 rr=0", cdb_valid, rr_ptr);
        end
        reset    = 1'b0;
        flush    = 1'b0;
        fu_valid = 4'b0000;
        m_rr     = 0;
    endtask

    // All FUs request continuously; a granted FU presents a fresh request.
    task automatic test_fairness();
        int          wait_cnt [N_FU];
        logic [3:0]  g;
        flush    = 1'b0;
        fu_valid = 4'hF;
        for (int i = 0; i < N_FU; i++) begin
            new_request(i);
            wait_cnt[i] = 0;
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            model_eval();
            n_checks++;
            if (fu_grant !== exp_grant) begin
                n_errors++;
                $display("FAIL fair_grant cyc=%0d got=%b exp=%b", cyc, fu_grant, exp_grant);
            end
            g = fu_grant;
            for (int i = 0; i < N_FU; i++) begin
                if (g[i]) wait_cnt[i] = 0;
                else      wait_cnt[i]++;
                n_checks++;
                if (wait_cnt[i] >= 2) begin
                    n_errors++;
                    $display("FAIL starve fu=%0d cyc=%0d waited=%0d exp<2", i, cyc, wait_cnt[i]);
                end
            end
            @(posedge clock); #1;
            n_checks++;
            if (cdb_valid !== n_valid || cdb_tag !== n_tag || cdb_take_branch !== n_br
                || cdb_br_target !== n_tgt || rr_ptr !== 2'(n_rr)) begin
                n_errors++;
                $display("FAIL fair_out cyc=%0d got v=%b t=%h b=%b tg=%h rr=%0d exp v=%b t=%h b=%b tg=%h rr=%0d",
                         cyc, cdb_valid, cdb_tag, cdb_take_branch, cdb_br_target, rr_ptr,
                         n_valid, n_tag, n_br, n_tgt, n_rr);
            end
            m_rr = n_rr;
            for (int i = 0; i < N_FU; i++) if (g[i]) new_request(i);
        end
        fu_valid = 4'b0000;
    endtask

    // Unconstrained traffic: null tags, flushes and occasional resets.
    task automatic test_random_mixed();
        for (int cyc = 0; cyc < 150; cyc++) begin
            reset          = ($urandom_range(39) == 0);
            flush          = ($urandom_range(7) == 0);
            fu_valid       = 4'($urandom);
            fu_take_branch = 4'($urandom);
            for (int i = 0; i < N_FU; i++) begin
                fu_tag[i*TAG_W +: TAG_W]     = ($urandom_range(3) == 0) ? 6'd0 : 6'($urandom);
                fu_br_target[i*XLEN +: XLEN] = $urandom;
            end
            #1;
            model_eval();
            n_checks++;
            if (fu_grant !== exp_grant) begin
                n_errors++;
                $display("FAIL mix_grant cyc=%0d got=%b exp=%b", cyc, fu_grant, exp_grant);
            end
            @(posedge clock); #1;
            n_checks++;
            if (cdb_valid !== n_valid || cdb_tag !== n_tag || cdb_take_branch !== n_br
                || cdb_br_target !== n_tgt || rr_ptr !== 2'(n_rr)) begin
                n_errors++;
                $display("FAIL mix_out cyc=%0d got v=%b t=%h b=%b rr=%0d exp v=%b t=%h b=%b rr=%0d",
                         cyc, cdb_valid, cdb_tag, cdb_take_branch, rr_ptr,
                         n_valid, n_tag, n_br, n_rr);
            end
            m_rr = n_rr;
        end
        reset    = 1'b0;
        flush    = 1'b0;
        fu_valid = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_branch();
        test_null_tag();
        test_flush();
        test_fairness();
        test_random_mixed();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
